// File: rtl/add8u_err_eval.sv
// ---------------------------------------------------------------------------
// add8u_err_eval
// Exhaustive error evaluator for a WIDTH-bit approximate unsigned adder that
// returns WIDTH+1 bits. It sweeps every operand pair (A in the upper half of
// the index, B in the lower half) into the adder under test and compares the
// returned sum with the exact sum. It accumulates the figures used for MAE,
// MSE, WCE (with the operands of the first worst case) and error probability.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         single-cycle request to begin a full sweep (ignored when busy)
//   busy          high from the cycle after start is accepted until done
//   done          one-cycle pulse when the results are final
//   dut_a, dut_b  registered operands driven into the adder under test
//   dut_o         sum returned by the adder under test (DUT_LAT cycles later)
//   sum_abs_err   sum of |dut_o - (A+B)|
//   sum_sq_err    sum of (dut_o - (A+B))^2
//   wce           largest absolute error seen
//   wce_a, wce_b  operands of the first pair that produced wce
//   err_cnt       number of pairs with a nonzero error
// ---------------------------------------------------------------------------
module add8u_err_eval #(
  parameter int WIDTH   = 8,
  parameter int DUT_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic [WIDTH:0]     dut_o,
  output logic [3*WIDTH:0]   sum_abs_err,
  output logic [4*WIDTH+1:0] sum_sq_err,
  output logic [WIDTH:0]     wce,
  output logic [WIDTH-1:0]   wce_a,
  output logic [WIDTH-1:0]   wce_b,
  output logic [2*WIDTH:0]   err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [2*WIDTH-1:0] idx_q;
  logic               issue;
  logic               last_pair;
  logic               accept;
  logic               pipe_busy;

  // Issue register (stage 0) followed by DUT_LAT alignment stages. The exact
  // sum and the operands ride along with the valid bit so that the entry at
  // index DUT_LAT lines up with dut_o.
  logic [DUT_LAT:0]   pv_q;
  logic [WIDTH:0]     px_q [0:DUT_LAT];
  logic [WIDTH-1:0]   pa_q [0:DUT_LAT];
  logic [WIDTH-1:0]   pb_q [0:DUT_LAT];

  // Error stage: registered absolute error plus its operands.
  logic               ev_q;
  logic [WIDTH:0]     eabs_q;
  logic [WIDTH-1:0]   ea_q;
  logic [WIDTH-1:0]   eb_q;

  logic signed [WIDTH+1:0] diff;
  logic [WIDTH:0]          abs_now;
  logic [2*WIDTH+1:0]      sq;

  assign issue     = (state_q == S_RUN);
  assign last_pair = issue && (idx_q == '1);
  assign accept    = (state_q == S_IDLE) && start;
  assign pipe_busy = (|pv_q) | ev_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dut_a     = pa_q[0];
  assign dut_b     = pb_q[0];

  // The difference never exceeds 2^(WIDTH+1)-1 in magnitude, so negating
  // only the low WIDTH+1 bits gives the exact magnitude.
  always_comb begin
    diff    = $signed({1'b0, dut_o}) - $signed({1'b0, px_q[DUT_LAT]});
    abs_now = diff[WIDTH+1] ? (~diff[WIDTH:0] + 1'b1) : diff[WIDTH:0];
    sq      = {{(WIDTH+1){1'b0}}, eabs_q} * {{(WIDTH+1){1'b0}}, eabs_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: DRAIN waits for every valid bit in flight to retire so the
  // last pair has been accumulated before DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_RUN;
      S_RUN:   if (last_pair)  state_d = S_DRAIN;
      S_DRAIN: if (!pipe_busy) state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Index counter, issue/alignment pipeline, error stage and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      pv_q        <= '0;
      for (int i = 0; i <= DUT_LAT; i++) begin
        px_q[i] <= '0;
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
      ev_q        <= 1'b0;
      eabs_q      <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      wce         <= '0;
      wce_a       <= '0;
      wce_b       <= '0;
      err_cnt     <= '0;
    end else begin
      pv_q[0] <= issue;
      if (issue) begin
        pa_q[0] <= idx_q[2*WIDTH-1:WIDTH];
        pb_q[0] <= idx_q[WIDTH-1:0];
        px_q[0] <= {1'b0, idx_q[2*WIDTH-1:WIDTH]} + {1'b0, idx_q[WIDTH-1:0]};
        if (!last_pair) begin
          idx_q <= idx_q + 1'b1;
        end
      end

      for (int i = 1; i <= DUT_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        px_q[i] <= px_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end

      ev_q   <= pv_q[DUT_LAT];
      eabs_q <= abs_now;
      ea_q   <= pa_q[DUT_LAT];
      eb_q   <= pb_q[DUT_LAT];

      if (accept) begin
        idx_q       <= '0;
        sum_abs_err <= '0;
        sum_sq_err  <= '0;
        wce         <= '0;
        wce_a       <= '0;
        wce_b       <= '0;
        err_cnt     <= '0;
      end else if (ev_q) begin
        sum_abs_err <= sum_abs_err + {{(2*WIDTH){1'b0}}, eabs_q};
        sum_sq_err  <= sum_sq_err + {{(2*WIDTH){1'b0}}, sq};
        err_cnt     <= err_cnt + {{(2*WIDTH){1'b0}}, |eabs_q};
        // Strictly greater: ties keep the earliest pair in sweep order.
        if (eabs_q > wce) begin
          wce   <= eabs_q;
          wce_a <= ea_q;
          wce_b <= eb_q;
        end
      end
    end
  end

endmodule
